// File: rtl/program_sequencer.sv
// Fetch/sequencing controller: owns the PC, launches resident programs, applies branches, detects halt.
// Optional taken-branch counter is built only when PROGRAM_SEQUENCER_BRCNT_EN is defined.
module program_sequencer #(
  parameter int unsigned     PC_W        = 8,
  parameter logic [PC_W-1:0] PROG0_START = PC_W'(0),
  parameter logic [PC_W-1:0] PROG1_START = PC_W'(100),
  parameter logic [PC_W-1:0] PROG2_START = PC_W'(152),
  parameter logic [7:0]      HALT_OPCODE = 8'b10001000,
  parameter int unsigned     CYC_W       = 16,
  parameter logic [CYC_W-1:0] WDOG_LIMIT = CYC_W'(16'hFFFF)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       prog_sel_i,
  input  logic             abort_i,
  input  logic [7:0]       inst_i,
  output logic [PC_W-1:0]  rom_addr_o,
  output logic [7:0]       inst_o,
  output logic             inst_valid_o,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             branch_back_i,
  input  logic [7:0]       branch_off_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CYC_W-1:0] cycle_count_o,
  output logic [CYC_W-1:0] branch_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              is_halt;
  logic              sel_ok;
  logic [PC_W-1:0]   entry_pc;
  logic [PC_W-1:0]   off_w;
  logic [PC_W-1:0]   pc_seq;
  logic [PC_W-1:0]   pc_next;
  logic [CYC_W-1:0]  cyc_inc;
  logic              wdog_hit;

  assign is_halt  = (inst_i == HALT_OPCODE);
  assign sel_ok   = (prog_sel_i != 2'd3);
  assign off_w    = PC_W'(branch_off_i);
  assign pc_seq   = pc_q + PC_W'(1);
  assign cyc_inc  = cyc_q + CYC_W'(1);
  assign wdog_hit = (cyc_inc == WDOG_LIMIT);

  always_comb begin
    entry_pc = PROG2_START;
    case (prog_sel_i)
      2'd0:    entry_pc = PROG0_START;
      2'd1:    entry_pc = PROG1_START;
      default: entry_pc = PROG2_START;
    endcase
  end

  // Branch target arithmetic wraps modulo 2^PC_W by construction.
  always_comb begin
    pc_next = pc_seq;
    if (branch_i) begin
      pc_next = branch_back_i ? (pc_seq - off_w) : (pc_seq + off_w);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cyc_d      = cyc_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_i) begin
          if (sel_ok) begin
            state_d    = S_RUN;
            pc_d       = entry_pc;
            cyc_d      = '0;
            err_code_d = 2'd0;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 2'd1;
          end
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          if (!stall_i && !is_halt) begin
            pc_d = pc_next;
          end
          // Watchdog outranks a halt seen in the same cycle.
          if (wdog_hit) begin
            state_d    = S_ERROR;
            err_code_d = 2'd2;
          end else if (!stall_i && is_halt) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cyc_q      <= '0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cyc_q      <= cyc_d;
      err_code_q <= err_code_d;
    end
  end

  assign rom_addr_o    = pc_q;
  assign inst_o        = inst_i;
  assign inst_valid_o  = (state_q == S_RUN) && !stall_i && !is_halt && !abort_i;
  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = (state_q == S_ERROR);
  assign err_code_o    = err_code_q;
  assign cycle_count_o = cyc_q;

`ifdef PROGRAM_SEQUENCER_BRCNT_EN
  logic [CYC_W-1:0] brc_q, brc_d;
  logic             brc_clr;
  logic             brc_adv;

  assign brc_clr = ((state_q == S_IDLE) || (state_q == S_ERROR)) && start_i && sel_ok;
  assign brc_adv = (state_q == S_RUN) && !stall_i && !abort_i && !is_halt && branch_i;

  always_comb begin
    brc_d = brc_q;
    if (brc_clr) begin
      brc_d = '0;
    end else if (brc_adv && (brc_q != '1)) begin
      brc_d = brc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      brc_q <= '0;
    end else begin
      brc_q <= brc_d;
    end
  end

  assign branch_count_o = brc_q;
`else
  assign branch_count_o = '0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer; watchdog limit lowered to 50 cycles.
module tb_program_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  prog_sel_i;
  logic        abort_i;
  logic [7:0]  inst_i;
  logic [7:0]  rom_addr_o;
  logic [7:0]  inst_o;
  logic        inst_valid_o;
  logic        stall_i;
  logic        branch_i;
  logic        branch_back_i;
  logic [7:0]  branch_off_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [15:0] cycle_count_o;
  logic [15:0] branch_count_o;

  int unsigned n_asrt = 0;
  int unsigned n_fail = 0;

  program_sequencer #(
    .WDOG_LIMIT(16'd50)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .prog_sel_i    (prog_sel_i),
    .abort_i       (abort_i),
    .inst_i        (inst_i),
    .rom_addr_o    (rom_addr_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .branch_back_i (branch_back_i),
    .branch_off_i  (branch_off_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o),
    .cycle_count_o (cycle_count_o),
    .branch_count_o(branch_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] brc_exp(input int unsigned n);
`ifdef PROGRAM_SEQUENCER_BRCNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic adv(input int unsigned n);
    branch_i = 1'b0;
    stall_i  = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; prog_sel_i = 2'd0; abort_i = 1'b0;
    inst_i = 8'h01; stall_i = 1'b0; branch_i = 1'b0; branch_back_i = 1'b0;
    branch_off_i = 8'd0;
    repeat (2) step();
    reset_i = 1'b0;
    step();
    chk("rst_addr", 32'(rom_addr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_cyc", 32'(cycle_count_o), 32'd0);
    chk("rst_brc", 32'(branch_count_o), 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);

    // Launch program 1 and walk sequentially.
    start_i = 1'b1; prog_sel_i = 2'd1;
    step();
    start_i = 1'b0; inst_i = 8'h5A;
    #1;
    chk("p1_entry", 32'(rom_addr_o), 32'd100);
    chk("p1_busy", 32'(busy_o), 32'd1);
    chk("p1_valid", 32'(inst_valid_o), 32'd1);
    chk("p1_inst_fwd", 32'(inst_o), 32'h5A);
    chk("p1_cyc0", 32'(cycle_count_o), 32'd0);
    adv(3);
    chk("p1_seq", 32'(rom_addr_o), 32'd103);
    chk("p1_cyc3", 32'(cycle_count_o), 32'd3);
    start_i = 1'b1; prog_sel_i = 2'd2;
    step();
    start_i = 1'b0;
    chk("start_in_run_ignored", 32'(rom_addr_o), 32'd104);
    abort_i = 1'b1;
    #1;
    chk("abort_valid", 32'(inst_valid_o), 32'd0);
    step();
    abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_pc_hold", 32'(rom_addr_o), 32'd104);
    chk("abort_cyc", 32'(cycle_count_o), 32'd5);

    // Branch arithmetic with program 0.
    start_i = 1'b1; prog_sel_i = 2'd0;
    step();
    start_i = 1'b0;
    chk("p0_entry", 32'(rom_addr_o), 32'd0);
    adv(17);
    chk("p0_pc17", 32'(rom_addr_o), 32'd17);
    branch_i = 1'b1; branch_back_i = 1'b0; branch_off_i = 8'd8;
    step();
    chk("br_fwd", 32'(rom_addr_o), 32'd26);
    adv(23);
    chk("p0_pc49", 32'(rom_addr_o), 32'd49);
    branch_i = 1'b1; branch_back_i = 1'b1; branch_off_i = 8'd38;
    step();
    chk("br_back", 32'(rom_addr_o), 32'd12);
    branch_back_i = 1'b0; branch_off_i = 8'd180;
    step();
    chk("br_fwd_big", 32'(rom_addr_o), 32'd193);
    branch_back_i = 1'b1; branch_off_i = 8'd30;
    step();
    chk("br_back_164", 32'(rom_addr_o), 32'd164);
    branch_back_i = 1'b0; branch_off_i = 8'd200;
    step();
    branch_i = 1'b0;
    chk("br_wrap", 32'(rom_addr_o), 32'd109);
    chk("br_cyc", 32'(cycle_count_o), 32'd45);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("br_abort_cyc", 32'(cycle_count_o), 32'd46);
    chk("br_count", 32'(branch_count_o), brc_exp(5));

    // Stall holds PC and ignores branch, counter still runs.
    start_i = 1'b1; prog_sel_i = 2'd0;
    step();
    start_i = 1'b0;
    adv(20);
    chk("st_pc20", 32'(rom_addr_o), 32'd20);
    stall_i = 1'b1; branch_i = 1'b1; branch_back_i = 1'b0; branch_off_i = 8'd5;
    #1;
    chk("st_valid", 32'(inst_valid_o), 32'd0);
    repeat (3) step();
    chk("st_pc_hold", 32'(rom_addr_o), 32'd20);
    chk("st_cyc", 32'(cycle_count_o), 32'd23);
    chk("st_busy", 32'(busy_o), 32'd1);
    stall_i = 1'b0; branch_i = 1'b0;
    #1;
    chk("st_release_valid", 32'(inst_valid_o), 32'd1);
    step();
    chk("st_release_pc", 32'(rom_addr_o), 32'd21);
    chk("st_brc", 32'(branch_count_o), 32'd0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;

    // Halt at pc 99 after 40 RUN cycles.
    start_i = 1'b1; prog_sel_i = 2'd0;
    step();
    start_i = 1'b0;
    branch_i = 1'b1; branch_back_i = 1'b0; branch_off_i = 8'd59;
    step();
    branch_i = 1'b0;
    chk("h_pc60", 32'(rom_addr_o), 32'd60);
    adv(39);
    chk("h_pc99", 32'(rom_addr_o), 32'd99);
    chk("h_cyc40", 32'(cycle_count_o), 32'd40);
    inst_i = 8'h88;
    #1;
    chk("h_valid", 32'(inst_valid_o), 32'd0);
    step();
    inst_i = 8'h01;
    chk("h_done", 32'(done_o), 32'd1);
    chk("h_busy", 32'(busy_o), 32'd0);
    chk("h_pc_hold", 32'(rom_addr_o), 32'd99);
    chk("h_cyc41", 32'(cycle_count_o), 32'd41);
    step();
    chk("h_done_pulse", 32'(done_o), 32'd0);
    chk("h_idle_busy", 32'(busy_o), 32'd0);
    chk("h_cyc_hold", 32'(cycle_count_o), 32'd41);
    chk("h_brc_hold", 32'(branch_count_o), brc_exp(1));

    // Invalid selection, then recovery from ERROR.
    start_i = 1'b1; prog_sel_i = 2'd3;
    step();
    chk("e_err", 32'(err_o), 32'd1);
    chk("e_code1", 32'(err_code_o), 32'd1);
    chk("e_valid", 32'(inst_valid_o), 32'd0);
    step();
    chk("e_stay", 32'(err_o), 32'd1);
    chk("e_stay_code", 32'(err_code_o), 32'd1);
    prog_sel_i = 2'd2;
    step();
    start_i = 1'b0;
    chk("e_exit_busy", 32'(busy_o), 32'd1);
    chk("e_exit_pc", 32'(rom_addr_o), 32'd152);
    chk("e_exit_err", 32'(err_o), 32'd0);
    chk("e_exit_code", 32'(err_code_o), 32'd0);
    chk("e_exit_cyc", 32'(cycle_count_o), 32'd0);

    // Looping branch until the watchdog; halt on the 50th cycle loses to it.
    branch_i = 1'b1; branch_back_i = 1'b1; branch_off_i = 8'd1;
    repeat (49) step();
    chk("w_busy", 32'(busy_o), 32'd1);
    chk("w_pc", 32'(rom_addr_o), 32'd152);
    chk("w_cyc49", 32'(cycle_count_o), 32'd49);
    inst_i = 8'h88;
    step();
    inst_i = 8'h01; branch_i = 1'b0;
    chk("w_err", 32'(err_o), 32'd1);
    chk("w_code2", 32'(err_code_o), 32'd2);
    chk("w_cyc50", 32'(cycle_count_o), 32'd50);
    chk("w_no_done", 32'(done_o), 32'd0);
    chk("w_brc", 32'(branch_count_o), brc_exp(49));

    // Reset mid-run.
    start_i = 1'b1; prog_sel_i = 2'd0;
    step();
    start_i = 1'b0;
    chk("r_busy", 32'(busy_o), 32'd1);
    chk("r_code_clr", 32'(err_code_o), 32'd0);
    adv(5);
    chk("r_pc5", 32'(rom_addr_o), 32'd5);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("r_idle", 32'(busy_o), 32'd0);
    chk("r_pc0", 32'(rom_addr_o), 32'd0);
    chk("r_cyc0", 32'(cycle_count_o), 32'd0);
    chk("r_done", 32'(done_o), 32'd0);
    step();
    chk("r_no_done", 32'(done_o), 32'd0);
    chk("r_still_idle", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Fetch/sequencing controller for the 8-bit accumulator-style core; owns the PC and drives the instruction ROM address, which is read combinationally.
- Launches one of three resident programs (multiply, string match, closest pair) on request.
- Applies the datapath's branch decisions and detects halt.
- Reports completion, cycle count and fault status to the host/testbench.

Parameters:
PC_W, 8, PC and ROM address width
PROG0_START, 0, entry address of program 0
PROG1_START, 100, entry address of program 1
PROG2_START, 152, entry address of program 2
HALT_OPCODE, 8'b10001000, encoding that terminates a program
CYC_W, 16, cycle counter width
WDOG_LIMIT, 16'hFFFF, RUN-cycle count at which the watchdog fault fires

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  launch request, sampled in IDLE/ERROR only
prog_sel_i  in  2  program index; 0..2 valid, 3 invalid
abort_i  in  1  terminate current run without done
inst_i  in  8  instruction from ROM data_o
rom_addr_o  out  PC_W  ROM address = PC register
inst_o  out  8  instruction forwarded to decoder (= inst_i)
inst_valid_o  out  1  datapath executes inst_o this cycle
stall_i  in  1  datapath busy; hold PC
branch_i  in  1  executed instruction is a taken branch
branch_back_i  in  1  1 = backward (branchb), 0 = forward
branch_off_i  in  8  branch offset from register
busy_o  out  1  state is RUN
done_o  out  1  one-cycle pulse on normal halt
err_o  out  1  state is ERROR
err_code_o  out  2  0 none, 1 bad prog_sel, 2 watchdog
cycle_count_o  out  CYC_W  RUN cycles of last/current run
branch_count_o  out  CYC_W  taken branches (optional feature)

Behaviour:
- Synchronous reset, active-high. Reset puts state in IDLE with PC=0, and sets busy_o, done_o, err_o, err_code_o, cycle_count_o and branch_count_o to 0. A reset mid-run aborts immediately; no done_o.
- States: IDLE, RUN, DONE, ERROR.
- IDLE:
  - start_i with prog_sel_i 0..2: PC <= PROGn_START, cycle_count_o <= 0, next state RUN.
  - start_i with prog_sel_i=3: next state ERROR, err_code_o=1.
- RUN:
  - busy_o=1. cycle_count_o increments every RUN cycle, including stalls.
  - inst_valid_o = !stall_i && inst_i != HALT_OPCODE && !abort_i.
  - Advance only when !stall_i; stall holds PC, and branch_i is ignored while stalled.
  - Next PC when advancing:
    - pc+1 if !branch_i
    - pc+1+branch_off_i if branch_i && !branch_back_i
    - pc+1-branch_off_i if branch_i && branch_back_i
  - Next-PC arithmetic is modulo 2^PC_W; wrap is silent.
  - inst_i==HALT_OPCODE with !stall_i: halt is not executed, PC holds, next state DONE.
  - abort_i has priority over halt and branch: next state IDLE, PC holds, no done_o.
  - Watchdog: cycle_count_o reaching WDOG_LIMIT while in RUN: next state ERROR, err_code_o=2. Watchdog has priority over halt in the same cycle.
  - start_i is ignored in RUN.
- DONE: lasts exactly one cycle, done_o=1, busy_o=0, then IDLE. cycle_count_o holds until the next valid start.
- ERROR:
  - err_o=1, inst_valid_o=0.
  - Exit by reset, or by start_i with a valid prog_sel_i (behaves as the IDLE launch and clears err_code_o).
  - start_i with sel=3 in ERROR stays in ERROR with err_code_o=1.
- Latency: start accepted at edge N; rom_addr_o=entry and first inst_valid_o in cycle N+1.
- Outside RUN: inst_valid_o=0 and rom_addr_o=PC.

Optional Feature:
- Macro: PROGRAM_SEQUENCER_BRCNT_EN.
- Defined: branch_count_o counts advancing cycles with branch_i=1. It clears on a valid start, saturates at all-ones, and holds after run end.
- Undefined: branch_count_o tied to 0 and no counter logic is built. The port exists in both builds.

Test Plan:
1. Reset, then start_i=1 with sel=1 -> next cycle rom_addr_o=100, busy_o=1, inst_valid_o=1. With no branches, rom_addr_o=103 after 3 more non-stalled cycles.
2. Sel=0 run; at pc=17 drive branch_i=1, back=0, off=8 -> rom_addr_o=26. At pc=49 drive back=1, off=38 -> rom_addr_o=12. At pc=193 drive back=1, off=30 -> rom_addr_o=164.
3. At pc=20 hold stall_i=1 for 3 cycles with branch_i=1 -> rom_addr_o stays 20, inst_valid_o=0, cycle_count_o still +3.
4. ROM returns HALT_OPCODE at pc=99 after 40 RUN cycles -> inst_valid_o=0, next cycle done_o=1 for one cycle, then IDLE with cycle_count_o held at 41.
5. start with sel=3 -> err_o=1, err_code_o=1. Then start with sel=2 -> RUN with rom_addr_o=152, err_o=0.
6. WDOG_LIMIT=50 with a looping branch -> ERROR, err_code_o=2 at count 50. Separately, reset_i mid-run -> IDLE, PC=0, no done_o pulse.
